// File: rtl/div_unit_multi_if.sv
// Handshake and operand bus between the EX stage and the iterative divider.
interface div_unit_multi_if #(parameter int XLEN = 32);
  logic            start;
  logic            kill;
  logic [1:0]      div_op;
  logic            is_word_op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            ready;

  modport master (output start, kill, div_op, is_word_op, dividend, divisor,
                  input  result, busy, ready);
  modport slave  (input  start, kill, div_op, is_word_op, dividend, divisor,
                  output result, busy, ready);
endinterface

// File: rtl/div_unit_multi.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU (+W forms), BITS_PER_CYCLE quotient
// bits per cycle, with early-out for |a| < |b| and a flush input.

// One restoring step: shift the next dividend bit into the partial remainder, trial subtract.
module div_unit_multi_step #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0] r_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] r_o,
  output logic [XLEN-1:0] q_o
);
  logic [XLEN:0] rw;
  logic          lt;

  assign rw  = {r_i, q_i[XLEN-1]};
  assign lt  = rw < {1'b0, d_i};
  // rw < 2*d always holds, so the difference fits back into XLEN bits
  assign r_o = lt ? rw[XLEN-1:0] : XLEN'(rw - {1'b0, d_i});
  assign q_o = {q_i[XLEN-2:0], ~lt};
endmodule

module div_unit_multi #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 1
) (
  input logic             clk,
  input logic             reset_n,
  div_unit_multi_if.slave io
);
  localparam int B = BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state, state_nxt;

  logic            word, sgn, a_neg, b_neg, div0, ovf, early, special, accept;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_w;
  logic [6:0]      n_steps;

  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic [6:0]      cnt_q;
  logic            neg_q_q, neg_r_q, rem_sel_q, word_q, ready_q;

  logic [B:0][XLEN-1:0] r_ch, q_ch;
  logic [XLEN-1:0]      qv, rv, v, res_d;

  // operand conditioning at accept
  assign word  = (XLEN == 64) && io.is_word_op;
  assign sgn   = ~io.div_op[0];
  assign a_ext = word ? (sgn ? XLEN'($signed(io.dividend[31:0])) : XLEN'(io.dividend[31:0]))
                      : io.dividend;
  assign b_ext = word ? (sgn ? XLEN'($signed(io.divisor[31:0]))  : XLEN'(io.divisor[31:0]))
                      : io.divisor;
  assign a_neg = sgn & a_ext[XLEN-1];
  assign b_neg = sgn & b_ext[XLEN-1];
  assign mag_a = a_neg ? -a_ext : a_ext;
  assign mag_b = b_neg ? -b_ext : b_ext;
  assign min_w = word ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};

  assign div0    = (b_ext == '0);
  assign ovf     = sgn && (a_ext == min_w) && (&b_ext);
  assign early   = (EARLY_OUT != 0) && (mag_a < mag_b);
  assign special = div0 | ovf | early;
  assign accept  = (state == IDLE) && io.start && !io.kill;
  assign n_steps = word ? 7'(32 / B) : 7'(XLEN / B);

  // combinational chain of B restoring steps per COMPUTE cycle
  assign r_ch[0] = rem_q;
  assign q_ch[0] = quo_q;
  for (genvar i = 0; i < B; i++) begin : g_step
    div_unit_multi_step #(.XLEN(XLEN)) u_step (
      .r_i(r_ch[i]), .q_i(q_ch[i]), .d_i(dvsr_q), .r_o(r_ch[i+1]), .q_o(q_ch[i+1])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (io.kill) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (io.start) state_nxt = special ? DONE : COMPUTE;
        COMPUTE: if (cnt_q == 7'd0) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    io.busy   = (state != IDLE);
    io.ready  = ready_q;
    io.result = result_q;
  end

  // special cases preload the final quotient/remainder so DONE shares one output path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
    end else if (accept) begin
      dvsr_q    <= mag_b;
      cnt_q     <= n_steps - 7'd1;
      rem_sel_q <= io.div_op[1];
      word_q    <= word;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      if (div0) begin
        quo_q <= '1;
        rem_q <= a_ext;
      end else if (ovf) begin
        quo_q <= a_ext;
        rem_q <= '0;
      end else if (early) begin
        quo_q <= '0;
        rem_q <= a_ext;
      end else begin
        // word magnitudes are left-aligned so 32 shifts leave the quotient in [31:0]
        quo_q   <= word ? (mag_a << (XLEN - 32)) : mag_a;
        rem_q   <= '0;
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
      end
    end else if (state == COMPUTE) begin
      rem_q <= r_ch[B];
      quo_q <= q_ch[B];
      cnt_q <= cnt_q - 7'd1;
    end
  end

  assign qv    = neg_q_q ? -quo_q : quo_q;
  assign rv    = neg_r_q ? -rem_q : rem_q;
  assign v     = rem_sel_q ? rv : qv;
  assign res_d = word_q ? XLEN'($signed(v[31:0])) : v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= (state == DONE) && !io.kill;
      if ((state == DONE) && !io.kill) result_q <= res_d;
    end
  end
endmodule

// File: tb/tb_div_unit_multi.sv
// Drives one operation stream into six divider configurations and checks each against
// an arithmetic reference model (result and ready latency).
module tb_div_unit_multi;
  localparam int NC = 6;
  localparam int CX [NC] = '{32, 32, 32, 64, 64, 64};
  localparam int CB [NC] = '{1, 2, 4, 1, 2, 4};
  localparam int CE [NC] = '{1, 1, 0, 0, 1, 1};

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        start = 1'b0, kill = 1'b0, is_word_op = 1'b0;
  logic [1:0]  div_op = 2'b00;
  logic [63:0] dividend = '0, divisor = '0;

  logic [NC-1:0][63:0] res;
  logic [NC-1:0]       rdy, bsy;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int X = CX[g];
    div_unit_multi_if #(.XLEN(X)) bus ();
    assign bus.start      = start;
    assign bus.kill       = kill;
    assign bus.div_op     = div_op;
    assign bus.is_word_op = is_word_op;
    assign bus.dividend   = X'(dividend);
    assign bus.divisor    = X'(divisor);
    assign res[g] = 64'(bus.result);
    assign rdy[g] = bus.ready;
    assign bsy[g] = bus.busy;
    div_unit_multi #(.XLEN(X), .BITS_PER_CYCLE(CB[g]), .EARLY_OUT(CE[g])) u_dut (
      .clk(clk), .reset_n(reset_n), .io(bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference: plain signed arithmetic on the width-interpreted operands
  task automatic model(input int xlen, input int bpc, input int eo, input logic [1:0] op,
                       input logic wop, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output int lat);
    bit w;
    int wd;
    bit sg, ovf;
    logic signed [65:0] av, bv, q, rm, amin, aa, ab;
    logic [65:0] v;
    w  = (xlen == 64) && wop;
    wd = w ? 32 : xlen;
    sg = !op[0];
    if (wd == 32) begin
      if (sg) begin av = $signed(a[31:0]); bv = $signed(b[31:0]); end
      else begin av = $signed({34'b0, a[31:0]}); bv = $signed({34'b0, b[31:0]}); end
    end else begin
      if (sg) begin av = $signed(a); bv = $signed(b); end
      else begin av = $signed({2'b0, a}); bv = $signed({2'b0, b}); end
    end
    amin = -(66'sd1 <<< (wd - 1));
    ovf  = sg && (av == amin) && (bv == -66'sd1);
    if (bv == 0) begin q = -66'sd1; rm = av; end
    else if (ovf) begin q = av; rm = 0; end
    else begin q = av / bv; rm = av % bv; end
    v  = op[1] ? rm : q;
    aa = (av < 0) ? -av : av;
    ab = (bv < 0) ? -bv : bv;
    lat = (bv == 0 || ovf || (eo != 0 && aa < ab)) ? 2 : wd / bpc + 2;
    if (xlen == 32) r = {32'b0, v[31:0]};
    else if (w)     r = {{32{v[31]}}, v[31:0]};
    else            r = v[63:0];
  endtask

  // cycle 0 = start presented; cycle c is observed 1 time unit after the c-th edge
  task automatic run_op(input logic [1:0] op, input logic wop, input logic [63:0] a,
                        input logic [63:0] b, input bit noise);
    int lat [NC];
    bit got [NC];
    logic [63:0] cap [NC];
    logic [63:0] exp_r;
    int exp_l, cyc;
    bit all;
    @(negedge clk);
    div_op = op; is_word_op = wop; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
    div_op = 2'($urandom); is_word_op = 1'($urandom);
    cyc = 1;
    for (int g = 0; g < NC; g++) begin
      got[g] = 1'b0; lat[g] = 0; cap[g] = '0;
      chk($sformatf("busy_c1_%0d", g), 64'(bsy[g]), 64'd1);
    end
    while (1) begin
      all = 1'b1;
      for (int g = 0; g < NC; g++) begin
        if (!got[g]) begin
          if (rdy[g]) begin
            got[g] = 1'b1; lat[g] = cyc; cap[g] = res[g];
            chk($sformatf("busy_at_rdy_%0d", g), 64'(bsy[g]), 64'd0);
          end else all = 1'b0;
        end else if (cyc == lat[g] + 1) begin
          chk($sformatf("rdy_pulse_%0d", g), 64'(rdy[g]), 64'd0);
        end
      end
      if (all || cyc >= 100) break;
      // starts while every instance is still in COMPUTE must be ignored
      start = noise && cyc >= 2 && cyc <= 6;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    for (int g = 0; g < NC; g++) begin
      model(CX[g], CB[g], CE[g], op, wop, a, b, exp_r, exp_l);
      if (!got[g]) chk($sformatf("timeout_%0d", g), 64'd0, 64'd1);
      else begin
        chk($sformatf("lat_%0d op%0d w%0d %h/%h", g, op, wop, a, b), 64'(lat[g]), 64'(exp_l));
        chk($sformatf("res_%0d op%0d w%0d %h/%h", g, op, wop, a, b), cap[g], exp_r);
      end
    end
  endtask

  task automatic no_ready(input string tag, input int cycles);
    bit seen [NC];
    for (int g = 0; g < NC; g++) seen[g] = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      for (int g = 0; g < NC; g++) if (rdy[g]) seen[g] = 1'b1;
    end
    for (int g = 0; g < NC; g++) chk($sformatf("%s_%0d", tag, g), 64'(seen[g]), 64'd0);
  endtask

  initial begin
    logic [63:0] prev [NC];
    logic [63:0] a, b;
    int k;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NC; g++) begin
      chk($sformatf("rst_res_%0d", g), res[g], 64'd0);
      chk($sformatf("rst_rdy_%0d", g), 64'(rdy[g]), 64'd0);
      chk($sformatf("rst_busy_%0d", g), 64'(bsy[g]), 64'd0);
    end
    @(negedge clk); reset_n = 1'b1;

    run_op(2'b00, 1'b0, -64'sd7, 64'd2, 1'b0);
    run_op(2'b10, 1'b0, -64'sd7, 64'd2, 1'b0);
    run_op(2'b01, 1'b0, 64'd5, 64'd0, 1'b0);
    run_op(2'b11, 1'b0, 64'd5, 64'd0, 1'b0);
    run_op(2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000, '1, 1'b0);
    run_op(2'b10, 1'b1, 64'hFFFF_FFFF_8000_0000, '1, 1'b0);
    run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b0);
    run_op(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0);
    run_op(2'b10, 1'b1, -64'sd9, 64'd4, 1'b0);
    run_op(2'b01, 1'b0, 64'd3, 64'd10, 1'b0);
    run_op(2'b11, 1'b0, 64'd3, 64'd10, 1'b0);
    run_op(2'b01, 1'b0, 64'd1000, 64'd3, 1'b1);

    // kill in COMPUTE cycle 5
    for (int g = 0; g < NC; g++) prev[g] = res[g];
    @(negedge clk);
    div_op = 2'b01; is_word_op = 1'b0; dividend = 64'd1000; divisor = 64'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    for (int g = 0; g < NC; g++) chk($sformatf("kill_busy_%0d", g), 64'(bsy[g]), 64'd0);
    no_ready("kill_rdy", 80);
    for (int g = 0; g < NC; g++) chk($sformatf("kill_res_%0d", g), res[g], prev[g]);
    run_op(2'b00, 1'b0, 64'd1000, -64'sd7, 1'b0);

    // start and kill together: nothing accepted
    @(negedge clk);
    div_op = 2'b01; dividend = 64'd77; divisor = 64'd5; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1; start = 1'b0; kill = 1'b0;
    for (int g = 0; g < NC; g++) chk($sformatf("sk_busy_%0d", g), 64'(bsy[g]), 64'd0);
    no_ready("sk_rdy", 80);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 5);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (k)
        1: b = '0;
        2: begin a = ($urandom_range(0, 1) != 0) ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
        3: begin a = 64'($urandom_range(0, 50)); b = 64'($urandom_range(1, 50));
                 if ($urandom_range(0, 1) != 0) a = -a;
                 if ($urandom_range(0, 1) != 0) b = -b; end
        4: b = 64'($urandom_range(1, 1000));
        5: b = {32'($urandom), 32'($urandom_range(1, 255))};
        default: ;
      endcase
      run_op(2'($urandom), 1'($urandom), a, b, 1'b0);
    end

    // asynchronous reset mid-operation
    @(negedge clk);
    div_op = 2'b00; is_word_op = 1'b0; dividend = 64'd12345; divisor = 64'd17; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int g = 0; g < NC; g++) begin
      chk($sformatf("arst_busy_%0d", g), 64'(bsy[g]), 64'd0);
      chk($sformatf("arst_res_%0d", g), res[g], 64'd0);
    end
    @(negedge clk); reset_n = 1'b1;
    no_ready("arst_rdy", 80);
    run_op(2'b10, 1'b0, -64'sd100, 64'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
